// File: rtl/mul4_share_arbiter_pkg.sv
// Shared types and helpers for the shared 4x4 multiplier arbiter.
// Holds operand widths, slice helper and a reusable round-robin search.
package mul4_share_arbiter_pkg;

  localparam int MUL_W  = 4;
  localparam int PROD_W = 8;
  localparam int MAXREQ = 8;

  typedef logic [MUL_W-1:0] opnd_t;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } rr_pick_t;

  function automatic opnd_t opnd_slice(
    input logic [MUL_W*MAXREQ-1:0] vec,
    input int                      i
  );
    return vec[MUL_W*i +: MUL_W];
  endfunction

  // Rotate so ptr sits at bit 0, find lowest set bit, map back.
  function automatic rr_pick_t rr_find(
    input logic [MAXREQ-1:0] req,
    input logic [2:0]        ptr,
    input int                n
  );
    logic [MAXREQ-1:0] rot;
    rr_pick_t          r;
    int                idx;
    int                pos;
    rot = '0;
    r   = '0;
    pos = 0;
    for (int k = 0; k < MAXREQ; k++) begin
      idx = (int'(ptr) + k) % n;
      if (k < n) rot[k] = req[idx[2:0]];
    end
    for (int k = MAXREQ - 1; k >= 0; k--) begin
      if (rot[k]) pos = k;
    end
    r.found = |rot;
    r.idx   = 3'((int'(ptr) + pos) % n);
    return r;
  endfunction

endpackage

// File: rtl/mul4_share_arbiter_if.sv
// Requester and response channel bundle for the shared multiplier.
// slave faces the arbiter, master faces requesters and consumer.
interface mul4_share_arbiter_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
);
  import mul4_share_arbiter_pkg::*;

  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [MUL_W*NREQ-1:0] req_a;
  logic [MUL_W*NREQ-1:0] req_b;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [PROD_W-1:0]     rsp_product;
  logic [15:0]           grant_count;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_product, grant_count
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_product, grant_count
  );

endinterface

// File: rtl/mul4_share_arbiter_mul.sv
// Combinational 4x4 unsigned array multiplier.
// Each row ripples a full-adder chain over the shifted partial sum.
module mul4x4_array
  import mul4_share_arbiter_pkg::*;
(
  input  opnd_t             a,
  input  opnd_t             b,
  output logic [PROD_W-1:0] p
);

  always_comb begin
    logic [MUL_W-1:0] hi;
    logic [MUL_W-1:0] pp;
    logic [MUL_W-1:0] t;
    logic             c;
    p  = '0;
    pp = a & {MUL_W{b[0]}};
    p[0] = pp[0];
    hi = {1'b0, pp[MUL_W-1:1]};
    for (int i = 1; i < MUL_W; i++) begin
      pp = a & {MUL_W{b[i]}};
      c  = 1'b0;
      t  = '0;
      for (int j = 0; j < MUL_W; j++) begin
        t[j] = pp[j] ^ hi[j] ^ c;
        c    = (pp[j] & hi[j]) | (c & (pp[j] ^ hi[j]));
      end
      p[i] = t[0];
      hi   = {c, t[MUL_W-1:1]};
    end
    p[PROD_W-1:MUL_W] = hi;
  end

endmodule

// File: rtl/mul4_share_arbiter.sv
// Round-robin arbiter sharing one 4x4 multiplier among NREQ requesters.
// One output register holds the result; it refills while draining.
module mul4_share_arbiter
  import mul4_share_arbiter_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input logic                clk,
  input logic                rst,
  mul4_share_arbiter_if.slave bus
);

  logic [2:0]               rr_ptr;
  logic [2:0]               ptr_nxt;
  logic [MAXREQ-1:0]        vld8;
  logic [MUL_W*MAXREQ-1:0]  a_all;
  logic [MUL_W*MAXREQ-1:0]  b_all;
  rr_pick_t                 pick;
  logic                     can_issue;
  logic                     accept;
  logic [NREQ-1:0]          grant;
  opnd_t                    mux_a;
  opnd_t                    mux_b;
  logic [PROD_W-1:0]        prod;
  logic                     rsp_valid_q;
  logic [IDW-1:0]           rsp_id_q;
  logic [PROD_W-1:0]        rsp_prod_q;
  logic [15:0]              gcnt;

  always_comb begin
    vld8  = '0;
    a_all = '0;
    b_all = '0;
    vld8[NREQ-1:0]        = bus.req_valid;
    a_all[MUL_W*NREQ-1:0] = bus.req_a;
    b_all[MUL_W*NREQ-1:0] = bus.req_b;
    can_issue = !rsp_valid_q || bus.rsp_ready;
    pick      = rr_find(vld8, rr_ptr, NREQ);
    accept    = pick.found && can_issue && !rst;
    grant = '0;
    mux_a = '0;
    mux_b = '0;
    // One-hot operand mux keeps a single multiplier instance.
    for (int i = 0; i < NREQ; i++) begin
      grant[i] = accept && (pick.idx == 3'(i));
      if (grant[i]) begin
        mux_a = mux_a | opnd_slice(a_all, i);
        mux_b = mux_b | opnd_slice(b_all, i);
      end
    end
    ptr_nxt = (int'(pick.idx) == NREQ - 1) ? 3'd0 : pick.idx + 3'd1;
  end

  mul4x4_array u_mul (
    .a (mux_a),
    .b (mux_b),
    .p (prod)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_prod_q  <= '0;
      gcnt        <= '0;
      rr_ptr      <= '0;
    end else if (accept) begin
      rsp_valid_q <= 1'b1;
      rsp_id_q    <= IDW'(pick.idx);
      rsp_prod_q  <= prod;
      gcnt        <= gcnt + 16'd1;
      rr_ptr      <= ptr_nxt;
    end else if (bus.rsp_ready) begin
      rsp_valid_q <= 1'b0;
    end
  end

  assign bus.req_ready   = grant;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_id      = rsp_id_q;
  assign bus.rsp_product = rsp_prod_q;
  assign bus.grant_count = gcnt;

endmodule

// File: tb/tb_mul4_share_arbiter.sv
// Self-checking bench: per-cycle reference model plus directed vectors.
// Model tracks pointer, response slot and counter from behavioural rules.
module tb_mul4_share_arbiter;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mul4_share_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

  mul4_share_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state
  int m_ptr   = 0;
  int m_valid = 0;
  int m_id    = 0;
  int m_prod  = 0;
  int m_cnt   = 0;
  int m_acc   = 0;
  int m_w     = 0;
  int m_a     = 0;
  int m_b     = 0;
  int m_drain = 0;

  always @(negedge clk) begin
    if (!rst) begin
      logic [NREQ-1:0] exp_rdy;
      int i;
      exp_rdy = '0;
      m_acc   = 0;
      if (m_valid == 0 || bus.rsp_ready) begin
        for (int k = 0; k < NREQ; k++) begin
          i = (m_ptr + k) % NREQ;
          if (m_acc == 0 && bus.req_valid[i]) begin
            m_acc = 1;
            m_w   = i;
          end
        end
      end
      if (m_acc != 0) begin
        exp_rdy[m_w] = 1'b1;
        m_a = int'(bus.req_a[4*m_w +: 4]);
        m_b = int'(bus.req_b[4*m_w +: 4]);
      end
      m_drain = int'(bus.rsp_ready);
      chk("cyc_req_ready", int'(bus.req_ready), int'(exp_rdy));
      chk("cyc_rsp_valid", int'(bus.rsp_valid), m_valid);
      chk("cyc_rsp_id", int'(bus.rsp_id), m_id);
      chk("cyc_rsp_product", int'(bus.rsp_product), m_prod);
      chk("cyc_grant_count", int'(bus.grant_count), m_cnt);
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ptr = 0; m_valid = 0; m_id = 0; m_prod = 0; m_cnt = 0; m_acc = 0;
    end else if (m_acc != 0) begin
      m_prod  = (m_a * m_b) % 256;
      m_id    = m_w;
      m_valid = 1;
      m_ptr   = (m_w + 1) % NREQ;
      m_cnt   = (m_cnt + 1) % 65536;
      m_acc   = 0;
    end else if (m_drain != 0) begin
      m_valid = 0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  int exp_order [10] = '{0, 1, 2, 3, 0, 1, 2, 0, 1, 2};
  int obs;

  initial begin
    bus.req_valid = 4'b1111;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b0;
    #2;
    chk("rst_req_ready", int'(bus.req_ready), 0);
    chk("rst_rsp_valid", int'(bus.rsp_valid), 0);
    chk("rst_rsp_product", int'(bus.rsp_product), 0);
    chk("rst_grant_count", int'(bus.grant_count), 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    bus.req_valid = '0;

    // Single requester 3*5
    bus.req_valid = 4'b0001;
    bus.req_a     = 16'h0003;
    bus.req_b     = 16'h0005;
    bus.rsp_ready = 1'b1;
    #1;
    chk("single_ready", int'(bus.req_ready), 1);
    step();
    chk("single_valid", int'(bus.rsp_valid), 1);
    chk("single_id", int'(bus.rsp_id), 0);
    chk("single_product", int'(bus.rsp_product), 15);
    chk("single_count", int'(bus.grant_count), 1);
    bus.req_valid = '0;
    step();

    // Requester 2 sweeps all operand pairs back-to-back
    bus.req_valid = 4'b0100;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        bus.req_a[11:8] = 4'(a);
        bus.req_b[11:8] = 4'(b);
        step();
      end
    end
    chk("sweep_last_product", int'(bus.rsp_product), 225);
    chk("sweep_last_id", int'(bus.rsp_id), 2);
    chk("sweep_count", int'(bus.grant_count), 257);
    bus.req_valid = '0;
    step();

    // Round-robin with requester 3 dropping after first grant
    do_reset();
    bus.req_valid = 4'b1111;
    bus.req_a     = {4'd4, 4'd3, 4'd2, 4'd1};
    bus.req_b     = {4'd2, 4'd2, 4'd2, 4'd2};
    for (int n = 0; n < 10; n++) begin
      #1;
      obs = -1;
      for (int k = 0; k < NREQ; k++) if (bus.req_ready[k]) obs = k;
      chk("rr_order", obs, exp_order[n]);
      step();
      if (obs == 3) bus.req_valid[3] = 1'b0;
    end

    // Backpressure: slot holds requester 2's 3*2, pointer at 3
    bus.rsp_ready = 1'b0;
    bus.req_valid = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      #1;
      chk("bp_ready", int'(bus.req_ready), 0);
      chk("bp_product", int'(bus.rsp_product), 6);
      chk("bp_id", int'(bus.rsp_id), 2);
      step();
    end
    bus.rsp_ready = 1'b1;
    #1;
    chk("bp_resume_ready", int'(bus.req_ready), 8);
    step();
    chk("bp_resume_id", int'(bus.rsp_id), 3);
    chk("bp_resume_product", int'(bus.rsp_product), 8);

    // Drain and accept in the same cycle
    bus.req_valid = 4'b0001;
    bus.req_a     = {4'd4, 4'd3, 4'd2, 4'd2};
    bus.req_b     = {4'd2, 4'd2, 4'd2, 4'd3};
    step();
    chk("da_first_product", int'(bus.rsp_product), 6);
    bus.req_valid = 4'b0010;
    bus.req_a[7:4] = 4'd7;
    bus.req_b[7:4] = 4'd9;
    #1;
    chk("da_ready", int'(bus.req_ready), 2);
    step();
    chk("da_valid", int'(bus.rsp_valid), 1);
    chk("da_product", int'(bus.rsp_product), 63);
    chk("da_id", int'(bus.rsp_id), 1);
    chk("da_count", int'(bus.grant_count), 13);

    // Async reset between edges while a response is held
    bus.rsp_ready = 1'b0;
    bus.req_valid = 4'b0110;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", int'(bus.rsp_valid), 0);
    chk("arst_product", int'(bus.rsp_product), 0);
    chk("arst_count", int'(bus.grant_count), 0);
    chk("arst_ready", int'(bus.req_ready), 0);
    step();
    rst = 1'b0;
    bus.rsp_ready = 1'b1;
    #1;
    chk("arst_first_ready", int'(bus.req_ready), 2);
    step();
    chk("arst_first_id", int'(bus.rsp_id), 1);
    chk("arst_first_product", int'(bus.rsp_product), 63);
    chk("arst_first_count", int'(bus.grant_count), 1);
    bus.req_valid = '0;
    step();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
